// File: rtl/spi_ctrl_pkg.sv
// Shared types and helpers for the SPI display controller.
package spi_ctrl_pkg;

    localparam int DATA_W = 4;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RECV,
        ST_WAIT_END,
        ST_LOCAL
    } seq_state_t;

    function automatic logic [BYTE_W-1:0] pack_miso(input logic [DATA_W-1:0] d);
        return {d, {(BYTE_W - DATA_W){1'b0}}};
    endfunction

endpackage

// File: rtl/spi_display_sequencer_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/spi_display_sequencer.sv
// Frame sequencer between the SPI slave and the LED/7-seg decoder, with a
// local write port sharing the display value, a frame watchdog and error counters.
//
// state    | meaning
// IDLE     | no frame; serves a pending local write when SS is inactive
// LOAD     | frame start: MISO register loaded with the current value echo
// RECV     | waiting for the single byte of the frame, watchdog running
// WAIT_END | byte handled or frame timed out; waiting for SS release
// LOCAL    | local write granted and committed
module spi_display_sequencer
    import spi_ctrl_pkg::*;
#(
    parameter int FRAME_TIMEOUT = 50_000,
    parameter int TO_W          = 16,
    parameter int CNT_W         = 8
) (
    input  logic              FPGA_clk,
    input  logic              FPGA_reset,
    input  logic              ss_active,
    input  logic              rx_valid,
    input  logic [BYTE_W-1:0] rx_byte,
    output logic              tx_load,
    output logic [BYTE_W-1:0] tx_byte,
    input  logic              local_req,
    input  logic [DATA_W-1:0] local_data,
    output logic              local_gnt,
    output logic [DATA_W-1:0] led_value,
    output logic              frame_err,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  abort_count
);

    seq_state_t      state, state_nxt;
    logic [TO_W-1:0] wd;
    logic            wd_clear, wd_run, timeout;
    logic            commit_spi, commit_local;
    logic            err_inc, abort_inc;

    // Fires on the RECV cycle whose increment would make the watchdog reach the limit.
    assign timeout = (wd == TO_W'(FRAME_TIMEOUT - 1));

    always_ff @(posedge FPGA_clk or posedge FPGA_reset) begin
        if (FPGA_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        tx_load      = 1'b0;
        local_gnt    = 1'b0;
        frame_err    = 1'b0;
        commit_spi   = 1'b0;
        commit_local = 1'b0;
        err_inc      = 1'b0;
        abort_inc    = 1'b0;
        wd_clear     = 1'b0;
        wd_run       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ss_active) begin
                    state_nxt = ST_LOAD;
                end else if (local_req) begin
                    state_nxt = ST_LOCAL;
                end
            end
            ST_LOAD: begin
                tx_load   = 1'b1;
                wd_clear  = 1'b1;
                state_nxt = ST_RECV;
            end
            ST_RECV: begin
                wd_run = 1'b1;
                if (rx_valid) begin
                    if (rx_byte[BYTE_W-DATA_W-1:0] == '0) begin
                        commit_spi = 1'b1;
                    end else begin
                        frame_err = 1'b1;
                        err_inc   = 1'b1;
                    end
                    state_nxt = ss_active ? ST_WAIT_END : ST_IDLE;
                end else if (!ss_active) begin
                    abort_inc = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (timeout) begin
                    abort_inc = 1'b1;
                    state_nxt = ST_WAIT_END;
                end
            end
            ST_WAIT_END: begin
                if (!ss_active) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_LOCAL: begin
                local_gnt    = 1'b1;
                commit_local = 1'b1;
                state_nxt    = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge FPGA_clk or posedge FPGA_reset) begin
        if (FPGA_reset) begin
            wd <= '0;
        end else if (wd_clear) begin
            wd <= '0;
        end else if (wd_run) begin
            wd <= wd + 1'b1;
        end
    end

    // tx_byte lags led_value by one cycle; any commit is at least two cycles before the next LOAD.
    always_ff @(posedge FPGA_clk or posedge FPGA_reset) begin
        if (FPGA_reset) begin
            led_value <= '0;
            tx_byte   <= '0;
        end else begin
            if (commit_spi) begin
                led_value <= rx_byte[BYTE_W-1:BYTE_W-DATA_W];
            end else if (commit_local) begin
                led_value <= local_data;
            end
            tx_byte <= pack_miso(led_value);
        end
    end

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (FPGA_clk),
        .rst   (FPGA_reset),
        .inc   (err_inc),
        .clear (1'b0),
        .count (err_count)
    );

    sat_counter #(.W(CNT_W)) u_abort_cnt (
        .clk   (FPGA_clk),
        .rst   (FPGA_reset),
        .inc   (abort_inc),
        .clear (1'b0),
        .count (abort_count)
    );

endmodule

// File: tb/tb_spi_display_sequencer.sv
// Scoreboard bench: frame-level reference model queues expected output pulses; a monitor pops and compares.
module tb_spi_display_sequencer;

    localparam int K_LOAD = 0;
    localparam int K_ERR  = 1;
    localparam int K_GNT  = 2;

    typedef struct {
        int         kind;
        logic [7:0] tx;
        logic [3:0] led;
        logic [7:0] err;
        logic [7:0] abort;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       ss_active, rx_valid, local_req;
    logic [7:0] rx_byte;
    logic [3:0] local_data;
    logic       tx_load, local_gnt, frame_err;
    logic [7:0] tx_byte;
    logic [3:0] led_value;
    logic [7:0] err_count, abort_count;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    logic [3:0] m_led;
    logic [7:0] m_err, m_abort;

    spi_display_sequencer #(.FRAME_TIMEOUT(16), .TO_W(16), .CNT_W(8)) dut (
        .FPGA_clk    (clk),
        .FPGA_reset  (rst),
        .ss_active   (ss_active),
        .rx_valid    (rx_valid),
        .rx_byte     (rx_byte),
        .tx_load     (tx_load),
        .tx_byte     (tx_byte),
        .local_req   (local_req),
        .local_data  (local_data),
        .local_gnt   (local_gnt),
        .led_value   (led_value),
        .frame_err   (frame_err),
        .err_count   (err_count),
        .abort_count (abort_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    task automatic push(input int kind);
        exp_t e;
        e.kind  = kind;
        e.tx    = {m_led, 4'h0};
        e.led   = m_led;
        e.err   = m_err;
        e.abort = m_abort;
        q.push_back(e);
    endtask

    // Monitor: every output pulse must match the head of the scoreboard queue.
    always @(negedge clk) begin
        if (!rst && (tx_load || frame_err || local_gnt)) begin
            exp_t e;
            int   kind;
            chk("pulse_exclusive", 32'(tx_load) + 32'(frame_err) + 32'(local_gnt), 1);
            kind = tx_load ? K_LOAD : (frame_err ? K_ERR : K_GNT);
            if (q.size() == 0) begin
                chk("unexpected_pulse_kind", kind, 99);
            end else begin
                e = q.pop_front();
                chk("pulse_kind", kind, e.kind);
                if (kind == K_LOAD) chk("tx_byte_echo", tx_byte, e.tx);
                chk("led_at_pulse", led_value, e.led);
                chk("err_at_pulse", err_count, e.err);
                chk("abort_at_pulse", abort_count, e.abort);
            end
        end
    end

    task automatic rx_byte_apply(input logic [3:0] d, input logic [3:0] lo, input logic drop_ss);
        if (lo != 4'h0) push(K_ERR);
        rx_valid = 1'b1;
        rx_byte  = {d, lo};
        if (drop_ss) ss_active = 1'b0;
        step();
        rx_valid = 1'b0;
        if (lo == 4'h0) m_led = d;
        else m_err = sat_inc(m_err);
        chk("led_after_byte", led_value, m_led);
    endtask

    // typ: 0 byte in frame, 2 early release, 3 watchdog timeout, 4 byte with SS fall, 5 short SS pulse
    task automatic spi_frame(input int typ, input logic [3:0] d, input logic [3:0] lo, input int dly);
        push(K_LOAD);
        ss_active = 1'b1;
        step();
        if (typ == 5) begin
            ss_active = 1'b0;
            step();
            m_abort = sat_inc(m_abort);
            step();
            return;
        end
        step();
        repeat (dly) step();
        case (typ)
            0: begin
                rx_byte_apply(d, lo, 1'b0);
                repeat ($urandom_range(0, 3)) step();
                ss_active = 1'b0;
                step();
            end
            2: begin
                ss_active = 1'b0;
                m_abort = sat_inc(m_abort);
                step();
            end
            3: begin
                repeat (17) step();
                m_abort = sat_inc(m_abort);
                rx_valid = 1'b1;
                rx_byte  = {d, 4'h0};
                step();
                rx_valid = 1'b0;
                chk("late_byte_ignored", led_value, m_led);
                ss_active = 1'b0;
                step();
            end
            default: rx_byte_apply(d, lo, 1'b1);
        endcase
        step();
    endtask

    task automatic wait_gnt(input logic [3:0] d);
        logic seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (local_gnt) begin
                seen = 1'b1;
                break;
            end
        end
        chk("gnt_within_bound", 32'(seen), 1);
        local_req = 1'b0;
        m_led = d;
        step();
    endtask

    task automatic local_write(input logic [3:0] d);
        push(K_GNT);
        local_req  = 1'b1;
        local_data = d;
        wait_gnt(d);
    endtask

    task automatic local_during_frame(input logic [3:0] d_spi, input logic [3:0] d_loc);
        push(K_LOAD);
        local_req  = 1'b1;
        local_data = d_loc;
        ss_active  = 1'b1;
        step();
        step();
        rx_byte_apply(d_spi, 4'h0, 1'b0);
        step();
        push(K_GNT);
        ss_active = 1'b0;
        wait_gnt(d_loc);
    endtask

    initial begin
        int typ;
        rst = 1'b1; ss_active = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
        local_req = 1'b0; local_data = 4'h0;
        m_led = 4'h0; m_err = 8'h00; m_abort = 8'h00;
        repeat (10) step();
        chk("reset_led", led_value, 0);
        chk("reset_tx_byte", tx_byte, 0);
        chk("reset_counts", {err_count, abort_count}, 0);
        chk("reset_pulses", {tx_load, frame_err, local_gnt}, 0);
        rst = 1'b0;
        step();

        spi_frame(0, 4'h5, 4'h0, 0);
        spi_frame(0, 4'h5, 4'h3, 2);
        local_during_frame(4'hF, 4'hA);
        spi_frame(0, 4'h6, 4'h0, 1);
        spi_frame(5, 4'h0, 4'h0, 0);
        spi_frame(3, 4'h9, 4'h0, 0);
        spi_frame(4, 4'hC, 4'h0, 3);
        spi_frame(4, 4'h2, 4'h8, 0);
        local_write(4'h3);
        spi_frame(2, 4'h0, 4'h0, 4);

        for (int i = 0; i < 40; i++) begin
            typ = $urandom_range(0, 7);
            case (typ)
                0: spi_frame(0, 4'($urandom), 4'h0, $urandom_range(0, 10));
                1: spi_frame(0, 4'($urandom), 4'($urandom_range(1, 15)), $urandom_range(0, 10));
                2: spi_frame(2, 4'h0, 4'h0, $urandom_range(0, 8));
                3: spi_frame(3, 4'($urandom), 4'h0, 0);
                4: spi_frame(4, 4'($urandom), 4'($urandom_range(0, 1) * $urandom_range(1, 15)), $urandom_range(0, 10));
                5: spi_frame(5, 4'h0, 4'h0, 0);
                6: local_write(4'($urandom));
                default: local_during_frame(4'($urandom), 4'($urandom));
            endcase
        end

        chk("final_led", led_value, m_led);
        chk("final_err_count", err_count, m_err);
        chk("final_abort_count", abort_count, m_abort);

        push(K_LOAD);
        ss_active = 1'b1;
        step();
        step();
        rst = 1'b1;
        rx_valid = 1'b1;
        rx_byte = {~m_led, 4'h0};
        step();
        step();
        chk("midreset_led", led_value, 0);
        chk("midreset_tx_byte", tx_byte, 0);
        chk("midreset_counts", {err_count, abort_count}, 0);
        chk("midreset_pulses", {tx_load, frame_err, local_gnt}, 0);
        rx_valid = 1'b0;
        ss_active = 1'b0;
        m_led = 4'h0; m_err = 8'h00; m_abort = 8'h00;
        rst = 1'b0;
        repeat (3) step();
        chk("post_reset_idle", {tx_load, frame_err, local_gnt, led_value}, 0);
        spi_frame(0, 4'h7, 4'h0, 0);

        for (int i = 0; i < 20 && q.size() != 0; i++) step();
        chk("scoreboard_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
